// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package mult_pkg;

  localparam int XLEN       = 32;
  localparam int MULT_ITERS = 33;
  localparam int PROD_W     = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // One extra bit lets unsigned 32-bit operands be treated as positive 33-bit signed values.
  function automatic logic [XLEN:0] ext33(input logic [XLEN-1:0] v, input logic sgn);
    return {sgn & v[XLEN-1], v};
  endfunction

endpackage

// File: rtl/cla32.sv
// 32-bit two-level carry-lookahead adder: 4-bit lookahead groups chained by group carries.
module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        carryInput,
  output logic [31:0] sum,
  output logic        carryOutput
);

  logic [31:0] p;
  logic [31:0] g;
  logic [31:0] c;
  logic [7:0]  gp;
  logic [7:0]  gg;
  logic [8:0]  gc;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    c     = '0;
    gp    = '0;
    gg    = '0;
    gc    = '0;
    gc[0] = carryInput;
    for (int i = 0; i < 8; i++) begin
      gp[i] = &p[4*i +: 4];
      gg[i] = g[4*i+3]
            | (p[4*i+3] & g[4*i+2])
            | (p[4*i+3] & p[4*i+2] & g[4*i+1])
            | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
      gc[i+1] = gg[i] | (gp[i] & gc[i]);
      c[4*i]   = gc[i];
      c[4*i+1] = g[4*i] | (p[4*i] & gc[i]);
      c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i]) | (p[4*i+1] & p[4*i] & gc[i]);
      c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1]) | (p[4*i+2] & p[4*i+1] & g[4*i])
               | (p[4*i+2] & p[4*i+1] & p[4*i] & gc[i]);
    end
  end

  assign sum         = p ^ c;
  assign carryOutput = gc[8];

endmodule

// File: rtl/seq_mult32.sv
// Multi-cycle 32x32->64 radix-2 Booth multiplier (signed/unsigned), one cla32 add per clock.
module seq_mult32
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sgn,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  state_e              state_q, state_d;
  logic [XLEN:0]       a_q, a_d;
  logic [XLEN:0]       q_q, q_d;
  logic                qm1_q, qm1_d;
  logic [XLEN:0]       m_q, m_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                sub;
  logic [XLEN:0]       m_op;
  logic [XLEN-1:0]     sum_lo;
  logic                cout;
  logic [XLEN:0]       sum33;
  logic [XLEN:0]       acc;
  logic [XLEN:0]       a_sh;
  logic [XLEN:0]       q_sh;

  // Subtraction is A + ~M + 1; bit 32 is completed outside the 32-bit adder.
  assign sub  = q_q[0] & ~qm1_q;
  assign m_op = sub ? ~m_q : m_q;

  cla32 u_cla (
    .a           (a_q[XLEN-1:0]),
    .b           (m_op[XLEN-1:0]),
    .carryInput  (sub),
    .sum         (sum_lo),
    .carryOutput (cout)
  );

  assign sum33 = {a_q[XLEN] ^ m_op[XLEN] ^ cout, sum_lo};
  assign acc   = (q_q[0] ^ qm1_q) ? sum33 : a_q;
  assign a_sh  = {acc[XLEN], acc[XLEN:1]};
  assign q_sh  = {acc[0], q_q[XLEN:1]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          m_d     = ext33(a, sgn);
          q_d     = ext33(b, sgn);
          qm1_d   = 1'b0;
          a_d     = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d   = a_sh;
        q_d   = q_sh;
        qm1_d = q_q[0];
        cnt_d = (cnt_q == 6'(MULT_ITERS)) ? cnt_q : cnt_q + 6'd1;
        // Last iteration: the product is captured straight from the shifted next state.
        if (cnt_q == 6'(MULT_ITERS - 1)) begin
          state_d = DONE;
          prod_d  = {a_sh[XLEN-2:0], q_sh};
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: tb/tb_seq_mult32.sv
// Directed-vector bench for seq_mult32: product table, latency, busy/done handshake, reset abort.
module tb_seq_mult32;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[11];

  seq_mult32 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .sgn     (sgn),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Launch one operation and count edges after the start edge until done is seen.
  task automatic do_op(input logic [31:0] ai, input logic [31:0] bi, input logic si,
                       output logic [63:0] p, output int lat);
    @(negedge clk);
    a = ai; b = bi; sgn = si; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    p = product;
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic signed [63:0] sx, sy;
    logic [63:0] ux, uy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'h0, x};
    uy = {32'h0, y};
    return s ? 64'(sx * sy) : ux * uy;
  endfunction

  initial begin
    logic [63:0] p;
    logic [63:0] old_p;
    int          lat;
    int          pulses;
    logic [31:0] ra, rb;
    logic        rs;

    vecs[0]  = '{32'd3,          32'd5,          1'b0, 64'h0000_0000_0000_000F};
    vecs[1]  = '{32'hFFFF_FFFD,  32'd5,          1'b1, 64'hFFFF_FFFF_FFFF_FFF1};
    vecs[2]  = '{32'h8000_0000,  32'h8000_0000,  1'b1, 64'h4000_0000_0000_0000};
    vecs[3]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 64'hFFFF_FFFE_0000_0001};
    vecs[4]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 64'h0000_0000_0000_0001};
    vecs[5]  = '{32'h0000_0000,  32'h1234_5678,  1'b1, 64'h0000_0000_0000_0000};
    vecs[6]  = '{32'h7FFF_FFFF,  32'h7FFF_FFFF,  1'b1, 64'h3FFF_FFFF_0000_0001};
    vecs[7]  = '{32'h8000_0000,  32'h7FFF_FFFF,  1'b1, 64'hC000_0000_8000_0000};
    vecs[8]  = '{32'h8000_0000,  32'd2,          1'b0, 64'h0000_0001_0000_0000};
    vecs[9]  = '{32'hFFFF_FFFF,  32'd1,          1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[10] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 64'h0000_0000_FFFF_FFFF};

    // Reset with start held high: reset must win.
    rst = 1'b1; start = 1'b1; sgn = 1'b0; a = 32'd7; b = 32'd9;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {63'h0, busy}, 64'h0);
    chk("reset_done", {63'h0, done}, 64'h0);
    chk("reset_product", product, 64'h0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", {63'h0, busy}, 64'h0);

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sgn, p, lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
      chk($sformatf("vec%0d_product", i), p, vecs[i].exp);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_pulse", i), {63'h0, done}, 64'h0);
    end

    // Start during RUN is ignored; the first operation keeps its operands and timing.
    @(negedge clk);
    a = 32'd1000; b = 32'd2000; sgn = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("run_busy", {63'h0, busy}, 64'h1);
    lat = 0;
    repeat (9) begin
      @(posedge clk); #1;
      lat++;
    end
    @(negedge clk);
    a = 32'hDEAD_BEEF; b = 32'h1234_5678; sgn = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    lat++;
    start = 1'b0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ignored_start_latency", 64'(lat), 64'd33);
    chk("ignored_start_product", product, 64'd2000000);

    // Back-to-back start in the DONE cycle; old product held until the new DONE.
    old_p = product;
    @(negedge clk);
    a = 32'hFFFF_FFF0; b = 32'd16; sgn = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_done_low", {63'h0, done}, 64'h0);
    chk("b2b_busy_high", {63'h0, busy}, 64'h1);
    chk("b2b_product_held", product, old_p);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 32) chk("b2b_product_held_late", product, old_p);
    end
    chk("b2b_latency", 64'(lat), 64'd33);
    chk("b2b_product", product, 64'hFFFF_FFFF_FFFF_FF00);
    @(posedge clk); #1;
    chk("after_done_busy", {63'h0, busy}, 64'h0);

    // Reset in the middle of RUN aborts the operation.
    @(negedge clk);
    a = 32'd77; b = 32'd88; sgn = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", {63'h0, busy}, 64'h0);
    chk("abort_done", {63'h0, done}, 64'h0);
    chk("abort_product", product, 64'h0);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'd0);

    // Random operands against a 64-bit reference multiply.
    for (int n = 0; n < 200; n++) begin
      ra = $urandom;
      rb = $urandom;
      rs = n[0];
      do_op(ra, rb, rs, p, lat);
      chk($sformatf("rand%0d_%h_%h_s%0d", n, ra, rb, rs), p, ref_mul(ra, rb, rs));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
